// File: rtl/decode_queue.sv
// decode_queue
//   Decodes one 16-bit instruction per cycle into register indices, an
//   extended immediate and a jump displacement. The decoded bundle is stored
//   with its PC in a DEPTH-entry FIFO that feeds the execute stage.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous discard of all buffered entries (wins over push/pop)
//   in_valid   inst / in_pc valid
//   in_ready   FIFO has a free entry (registered-state function only)
//   inst       instruction word
//   in_pc      PC of inst
//   out_valid  head entry valid (count != 0)
//   out_ready  consumer takes the head entry this cycle
//   out_rs/rt/rd, out_imm, out_disp, out_wr, out_pc   head entry fields
//                                                     (all zero when empty)
//   count      number of occupied entries
module decode_queue #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_rs,
  output logic [2:0]        out_rt,
  output logic [2:0]        out_rd,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_disp,
  output logic              out_wr,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 9 + 2 * DATA_W + 1 + PC_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] f);
    logic [DATA_W-1:0] r;
    r = {DATA_W{f[4]}};
    r[4:0] = f;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] zext5(input logic [4:0] f);
    logic [DATA_W-1:0] r;
    r = '0;
    r[4:0] = f;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] f);
    logic [DATA_W-1:0] r;
    r = {DATA_W{f[7]}};
    r[7:0] = f;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] zext8(input logic [7:0] f);
    logic [DATA_W-1:0] r;
    r = '0;
    r[7:0] = f;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext11(input logic [10:0] f);
    logic [DATA_W-1:0] r;
    r = {DATA_W{f[10]}};
    r[10:0] = f;
    return r;
  endfunction

  // ---- stage p0: combinational decode of the incoming instruction ----
  logic [2:0]        cls_p0;
  logic [1:0]        sub_p0;
  logic [2:0]        rs_p0, rt_p0, rd_p0;
  logic [DATA_W-1:0] imm_p0, disp_p0;
  logic              wr_p0;
  logic [ENT_W-1:0]  ent_p0;

  assign cls_p0 = inst[15:13];
  assign sub_p0 = inst[12:11];

  always_comb begin
    rs_p0   = '0;
    rt_p0   = '0;
    rd_p0   = '0;
    imm_p0  = '0;
    disp_p0 = '0;
    wr_p0   = 1'b0;
    case (cls_p0)
      3'b010: begin
        rs_p0  = inst[10:8];
        rd_p0  = inst[7:5];
        imm_p0 = inst[12] ? zext5(inst[4:0]) : sext5(inst[4:0]);
        wr_p0  = 1'b1;
      end
      3'b101: begin
        rs_p0  = inst[10:8];
        rd_p0  = inst[7:5];
        imm_p0 = sext5(inst[4:0]);
        wr_p0  = 1'b1;
      end
      3'b100: begin
        rs_p0 = inst[10:8];
        if (sub_p0 == 2'b10) begin
          imm_p0 = zext8(inst[7:0]);
          wr_p0  = 1'b1;
        end else begin
          rd_p0  = inst[7:5];
          imm_p0 = sext5(inst[4:0]);
          wr_p0  = (sub_p0 != 2'b00);
        end
      end
      3'b110: begin
        rs_p0 = inst[10:8];
        wr_p0 = 1'b1;
        case (sub_p0)
          2'b00:   imm_p0 = sext8(inst[7:0]);
          2'b01:   rd_p0  = inst[4:2];
          default: begin
            rt_p0 = inst[7:5];
            rd_p0 = inst[4:2];
          end
        endcase
      end
      3'b111: begin
        rs_p0 = inst[10:8];
        rt_p0 = inst[7:5];
        rd_p0 = inst[4:2];
        wr_p0 = 1'b1;
      end
      3'b011: begin
        rs_p0  = inst[10:8];
        imm_p0 = sext8(inst[7:0]);
      end
      3'b001: begin
        case (sub_p0)
          2'b00: disp_p0 = sext11(inst[10:0]);
          2'b01: begin
            rs_p0  = inst[10:8];
            imm_p0 = sext8(inst[7:0]);
          end
          2'b10: begin
            disp_p0 = sext11(inst[10:0]);
            rd_p0   = 3'd7;
            wr_p0   = 1'b1;
          end
          default: begin
            rs_p0  = inst[10:8];
            imm_p0 = sext8(inst[7:0]);
            rd_p0  = 3'd7;
            wr_p0  = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign ent_p0 = {rs_p0, rt_p0, rd_p0, imm_p0, disp_p0, wr_p0, in_pc};

  // ---- stage p1: FIFO storage and occupancy ----
  logic [ENT_W-1:0] mem_p1 [DEPTH];
  logic [PTR_W-1:0] wr_ptr_p1, rd_ptr_p1;
  logic [CNT_W-1:0] count_p1;
  logic             push, pop;
  logic [ENT_W-1:0] head_p1;

  // Readiness depends only on stored occupancy, so a full FIFO refuses a
  // push even when the head is popped in the same cycle.
  assign in_ready  = (count_p1 < FULL);
  assign out_valid = (count_p1 != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      count_p1  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_p1[i] <= '0;
    end else if (flush) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      count_p1  <= '0;
    end else begin
      if (push) begin
        mem_p1[wr_ptr_p1] <= ent_p0;
        wr_ptr_p1         <= wr_ptr_p1 + 1'b1;
      end
      if (pop) rd_ptr_p1 <= rd_ptr_p1 + 1'b1;
      case ({push, pop})
        2'b10:   count_p1 <= count_p1 + 1'b1;
        2'b01:   count_p1 <= count_p1 - 1'b1;
        default: count_p1 <= count_p1;
      endcase
    end
  end

  // ---- head presentation: stale slot contents are masked when empty ----
  assign head_p1 = out_valid ? mem_p1[rd_ptr_p1] : '0;
  assign {out_rs, out_rt, out_rd, out_imm, out_disp, out_wr, out_pc} = head_p1;
  assign count = count_p1;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue
//   Bench for decode_queue (DATA_W = 16, PC_W = 16, DEPTH = 4). A queue-based
//   reference model predicts occupancy and head contents every cycle; directed
//   decode vectors, fill/drain, wrap, flush and asynchronous reset sequences
//   are followed by randomized traffic.
module tb_decode_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] imm;
    logic [15:0] disp;
    logic        wr;
    logic [15:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_wr;
  logic [15:0] inst, in_pc, out_imm, out_disp, out_pc;
  logic [2:0]  out_rs, out_rt, out_rd, count;

  int n_checks = 0;
  int n_pass   = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  decode_queue #(.DATA_W(16), .PC_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_imm(out_imm), .out_disp(out_disp), .out_wr(out_wr),
    .out_pc(out_pc), .count(count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Two's-complement extension of an n-bit field by integer arithmetic.
  function automatic logic [15:0] sx(input int v, input int n);
    int r;
    r = (v >= (1 << (n - 1))) ? v - (1 << n) : v;
    return 16'(r);
  endfunction

  function automatic ent_t ref_decode(input logic [15:0] i, input logic [15:0] pc);
    ent_t e;
    int cls, sub, v5, v8, v11;
    logic [2:0] rs, a, b;
    e = '0;
    e.pc = pc;
    cls = int'(i[15:13]);
    sub = int'(i[12:11]);
    rs  = i[10:8];
    a   = i[7:5];
    b   = i[4:2];
    v5  = int'(i[4:0]);
    v8  = int'(i[7:0]);
    v11 = int'(i[10:0]);
    case (cls)
      2: begin e.rs = rs; e.rd = a; e.imm = i[12] ? 16'(v5) : sx(v5, 5); e.wr = 1; end
      5: begin e.rs = rs; e.rd = a; e.imm = sx(v5, 5); e.wr = 1; end
      4: if (sub == 2) begin e.rs = rs; e.imm = 16'(v8); e.wr = 1; end
         else begin e.rs = rs; e.rd = a; e.imm = sx(v5, 5); e.wr = (sub != 0); end
      6: if (sub == 0) begin e.rs = rs; e.imm = sx(v8, 8); e.wr = 1; end
         else if (sub == 1) begin e.rs = rs; e.rd = b; e.wr = 1; end
         else begin e.rs = rs; e.rt = a; e.rd = b; e.wr = 1; end
      7: begin e.rs = rs; e.rt = a; e.rd = b; e.wr = 1; end
      3: begin e.rs = rs; e.imm = sx(v8, 8); end
      1: case (sub)
           0: e.disp = sx(v11, 11);
           1: begin e.rs = rs; e.imm = sx(v8, 8); end
           2: begin e.disp = sx(v11, 11); e.rd = 7; e.wr = 1; end
           default: begin e.rs = rs; e.imm = sx(v8, 8); e.rd = 7; e.wr = 1; end
         endcase
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_state();
    ent_t d, exp;
    d.rs = out_rs; d.rt = out_rt; d.rd = out_rd; d.imm = out_imm;
    d.disp = out_disp; d.wr = out_wr; d.pc = out_pc;
    exp = (q.size() != 0) ? q[0] : '0;
    check("count", 64'(count), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("head", 64'(d), 64'(exp));
  endtask

  task automatic drive(input bit v, input logic [15:0] i, input logic [15:0] pc,
                       input bit rdy, input bit fl);
    in_valid  = v;
    inst      = i;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  // One clock: predict handshakes from model occupancy, update model at the
  // edge, compare #1 later.
  task automatic tick();
    bit m_push, m_pop, m_fl;
    ent_t e;
    m_fl   = flush;
    m_push = in_valid && (q.size() < DEPTH) && !m_fl;
    m_pop  = (q.size() != 0) && out_ready && !m_fl;
    e      = ref_decode(inst, in_pc);
    @(posedge clk);
    if (m_fl) q.delete();
    else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(e);
    end
    #1;
    check_state();
  endtask

  task automatic push_one(input logic [15:0] i, input logic [15:0] pc);
    drive(1, i, pc, 0, 0);
    tick();
  endtask

  task automatic pop_one();
    drive(0, 16'h0, 16'h0, 1, 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 16'h0, 16'h0, 0, 0);
    #22;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    rst_n = 1'b1;

    // Directed decode vectors
    push_one(16'h4A3F, 16'h0010);
    check("v1_rs", 64'(out_rs), 64'd2);
    check("v1_rd", 64'(out_rd), 64'd1);
    check("v1_imm", 64'(out_imm), 64'hFFFF);
    check("v1_wr", 64'(out_wr), 64'd1);
    pop_one();
    push_one(16'h5A3F, 16'h0011);
    check("v2_imm", 64'(out_imm), 64'h001F);
    pop_one();
    push_one(16'hD94C, 16'h0012);
    check("v3_rs", 64'(out_rs), 64'd1);
    check("v3_rt", 64'(out_rt), 64'd2);
    check("v3_rd", 64'(out_rd), 64'd3);
    check("v3_imm", 64'(out_imm), 64'd0);
    pop_one();
    push_one(16'h37FF, 16'h0013);
    check("v4_disp", 64'(out_disp), 64'hFFFF);
    check("v4_rd", 64'(out_rd), 64'd7);
    check("v4_wr", 64'(out_wr), 64'd1);
    pop_one();
    push_one(16'h2905, 16'h0014);
    check("v5_rs", 64'(out_rs), 64'd1);
    check("v5_imm", 64'(out_imm), 64'h0005);
    pop_one();

    // Fill to full with PCs 0..4; PC 4 must be refused
    for (int k = 0; k < 5; k++) begin
      push_one(16'($urandom), 16'(k));
      if (k == 3) begin
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_count", 64'(count), 64'd4);
      end
    end
    check("full_hold_count", 64'(count), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check("drain_pc", 64'(out_pc), 64'(k));
      pop_one();
    end
    check("drain_count", 64'(count), 64'd0);

    // Continuous push/pop across pointer wrap
    push_one(16'($urandom), 16'd100);
    for (int k = 0; k < 3 * DEPTH; k++) begin
      drive(1, 16'($urandom), 16'(101 + k), 1, 0);
      tick();
      check("stream_count", 64'(count), 64'd1);
      check("stream_pc", 64'(out_pc), 64'(101 + k));
    end
    pop_one();

    // Flush with concurrent push at count = 3
    for (int k = 0; k < 3; k++) push_one(16'($urandom), 16'(200 + k));
    check("pre_flush_count", 64'(count), 64'd3);
    drive(1, 16'h4A3F, 16'd203, 0, 1);
    tick();
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    drive(0, 16'h0, 16'h0, 0, 0);
    tick();
    check("post_flush_count", 64'(count), 64'd0);

    // Asynchronous reset mid-stream at count = 2
    push_one(16'($urandom), 16'd300);
    push_one(16'($urandom), 16'd301);
    drive(0, 16'h0, 16'h0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("arst_count", 64'(count), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check_state();
    #2;
    rst_n = 1'b1;
    push_one(16'h2905, 16'd302);
    check("arst_push_rs", 64'(out_rs), 64'd1);
    check("arst_push_imm", 64'(out_imm), 64'h0005);
    pop_one();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
